fa16_rev_seq: RTL
=================

# fa16_rev_seq

Sequencer for one `fa16_rev` reversible 16-bit adder. Accepts compute (forward) and uncompute (backward) requests over a valid/ready handshake. It owns the adder's `dir` pin and enforces a turnaround gap between direction changes so the tristate pin buses never see two drivers. It keeps a LIFO history of forward results so each uncompute pops the most recent result and recovers the original operands. It sits between the PE issue logic and the adder instance.

## Interface
Parameters:
- `DEPTH`, 8: history stack entries (≥2).
- `SETTLE`, 2: cycles operands are held on the adder before capture (≥1).
- `TURN`, 1: idle cycles with all adder drives at 0 after a `dir` change (≥1).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid` / `in_ready`  in/out  1/1  request handshake.
- `in_op`  in  1  request type: 0 = compute, 1 = uncompute.
- `in_a`, `in_b`  in  16/16  compute operands.
- `in_c0`, `in_z`  in  1/1  compute carry-in and z.
- `out_valid` / `out_ready`  out/in  1/1  response handshake.
- `out_op`  out  1  echo of `in_op`.
- `out_err`  out  1  request rejected (stack full on compute, stack empty on uncompute).
- `out_mismatch`  out  1  recovered operands differ from the stored ones (see Configuration).
- `out_s`, `out_c15`  out  16/1  compute result.
- `out_a`, `out_b`, `out_c0`, `out_z`  out  16/16/1/1  uncompute result (recovered operands).
- `out_depth`  out  $clog2(DEPTH+1)  stack occupancy.
- `dir`  out  1  to the adder's `dir` pin.
- `f_a`, `f_b`, `f_c0_f`, `f_z`  out  16/16/1/1  forward drives to the adder.
- `f_s`, `f_a_b`, `f_c0_b`, `f_c15`  in  16/16/1/1  forward results from the adder.
- `r_s`, `r_a_b`, `r_c0_b`, `r_c15`  out  16/16/1/1  backward drives to the adder.
- `r_a`, `r_b`, `r_c0_f`, `r_z`  in  16/16/1/1  backward results from the adder.

## Operation
- FSM states: IDLE, TURN, SETTLE, RESP.
- `in_ready` = 1 only in IDLE with `rst` low. A request is accepted on `in_valid & in_ready`; operands are registered at acceptance.
- **Error check at accept.** A compute with depth==DEPTH, or an uncompute with depth==0, goes IDLE→RESP with `out_err`=1. In that case the stack, `dir` and all drives are unchanged and all data outputs are 0.
- **Direction change.** If the required direction (`in_op`) differs from `dir`, `dir` toggles registered at the accept edge and the FSM enters TURN for `TURN` cycles. Otherwise it goes straight to SETTLE.
- **SETTLE, compute.** `f_*` = registered operands; `r_*` = 0.
  - On the last SETTLE cycle, capture `f_s`/`f_c15` into `out_s`/`out_c15`.
  - Push {`f_s`, `f_a_b`, `f_c0_b`, `f_c15`} to `mem[depth]`; depth+1.
- **SETTLE, uncompute.** `r_*` = `mem[depth-1]`; `f_*` = 0.
  - On the last cycle, capture `r_a`, `r_b`, `r_c0_f`, `r_z` into the outputs; depth−1.
- **Drive rule.** Outside SETTLE, all `f_*` and `r_*` are 0. Drives never change in the same cycle as `dir`.
- **RESP.** Outputs are held stable until `out_ready`; then → IDLE. Response fields not belonging to `out_op` read 0.
- Back-to-back requests in the same direction skip TURN. `dir` holds its last value while idle.

## Timing
- Reset values: state IDLE, `dir`=0, depth=0, every output 0 (including `in_ready` while `rst` is high). Stack contents are not reset.
- Accept at cycle 0 → `out_valid` first high in cycle:
  - same direction: SETTLE+1;
  - direction change: TURN+SETTLE+1;
  - error: 1.
- Minimum issue interval: one cycle after the response handshake completes (the IDLE cycle).
- `rst` during TURN/SETTLE/RESP: abort immediately. No response is produced, no push or pop happens, depth=0, `dir`=0.
- `out_ready` held high in RESP: the response completes in one cycle.

## Configuration
- `FA16_REV_SEQ_CHECK_EN` defined:
  - Each stack entry also stores the original {a, b, c0, z} (34 + 34 bits per entry).
  - On uncompute, the recovered operands are compared against the stored ones; `out_mismatch`=1 in RESP if they differ.
- Undefined: entries are 34 bits and `out_mismatch` is tied 0.

## Test plan
- **Compute.** a=0x1234, b=0x0FF0, c0=0, z=0 (`dir` starts at 0, SETTLE=2) → `out_s`=0x2224, `out_c15`=0, `out_valid` at cycle 3, depth=1.
- **Uncompute after the above.** → `dir` toggles at accept, `out_valid` at cycle 4 (TURN=1), `out_a`=0x1234, `out_b`=0x0FF0, `out_c0`=0, `out_z`=0, `out_mismatch`=0, depth=0.
- **Carry out.** 0xFFFF + 0x0001, c0=0 → `out_s`=0x0000, `out_c15`=1. With c0=1 → `out_s`=0x0001, `out_c15`=1.
- **Stack limits.** 8 computes then a 9th → `out_err`=1 at cycle 1, depth stays 8. Then 8 uncomputes return the operands in LIFO order. A 9th uncompute → `out_err`=1.
- **Backpressure.** `out_ready` low for 3 RESP cycles → outputs stable, `in_ready`=0; completion on the cycle `out_ready` rises. Throughout, a checker asserts `f_*`/`r_*` are 0 whenever `dir` toggles or the FSM is in TURN.
- **Reset mid-SETTLE.** Assert `rst` in SETTLE cycle 1 of a compute → no `out_valid`, depth=0, `dir`=0. The next compute succeeds normally.

Source files
------------

// File: rtl/fa16_rev_seq.sv
// fa16_rev_seq: sequencer for one fa16_rev reversible 16-bit adder.
// It accepts compute and uncompute requests and owns the adder's dir pin.
// It holds all drives at 0 for TURN cycles after every dir change.
// It keeps a LIFO of forward results so each uncompute can replay the newest one.
// Optional feature: define FA16_REV_SEQ_CHECK_EN to also store the original operands.
// Each uncompute then compares its recovered operands against them.
module fa16_rev_seq #(
  parameter int DEPTH  = 8,
  parameter int SETTLE = 2,
  parameter int TURN   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_op,
  input  logic [15:0]                in_a,
  input  logic [15:0]                in_b,
  input  logic                       in_c0,
  input  logic                       in_z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_op,
  output logic                       out_err,
  output logic                       out_mismatch,
  output logic [15:0]                out_s,
  output logic                       out_c15,
  output logic [15:0]                out_a,
  output logic [15:0]                out_b,
  output logic                       out_c0,
  output logic                       out_z,
  output logic [$clog2(DEPTH+1)-1:0] out_depth,
  output logic                       dir,
  output logic [15:0]                f_a,
  output logic [15:0]                f_b,
  output logic                       f_c0_f,
  output logic                       f_z,
  input  logic [15:0]                f_s,
  input  logic [15:0]                f_a_b,
  input  logic                       f_c0_b,
  input  logic                       f_c15,
  output logic [15:0]                r_s,
  output logic [15:0]                r_a_b,
  output logic                       r_c0_b,
  output logic                       r_c15,
  input  logic [15:0]                r_a,
  input  logic [15:0]                r_b,
  input  logic                       r_c0_f,
  input  logic                       r_z
);

  localparam int DW   = $clog2(DEPTH + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (SETTLE > TURN) ? SETTLE : TURN;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_SETTLE, S_RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] depth;
  logic          op_q;
  logic [15:0]   a_q, b_q;
  logic          c0_q, z_q;
  logic [33:0]   mem [DEPTH];
`ifdef FA16_REV_SEQ_CHECK_EN
  logic [33:0]   chk_mem [DEPTH];
`endif

  logic          accept, req_err, stack_full, stack_empty;
  logic          last_turn, last_settle, recov_mismatch;
  logic [AW-1:0] push_idx, pop_idx;
  logic [33:0]   top_entry;

  assign stack_full  = (depth == DW'(DEPTH));
  assign stack_empty = (depth == '0);
  assign in_ready    = (state == S_IDLE) && !rst;
  assign accept      = in_valid && in_ready;
  assign req_err     = in_op ? stack_empty : stack_full;
  assign last_turn   = (state == S_TURN) && (cnt == CW'(TURN - 1));
  assign last_settle = (state == S_SETTLE) && (cnt == CW'(SETTLE - 1));
  assign push_idx    = AW'(depth);
  assign pop_idx     = AW'(depth - 1'b1);
  assign top_entry   = mem[pop_idx];
  assign out_valid   = (state == S_RESP);
  assign out_depth   = depth;

`ifdef FA16_REV_SEQ_CHECK_EN
  assign recov_mismatch = ({r_a, r_b, r_c0_f, r_z} != chk_mem[pop_idx]);
`else
  assign recov_mismatch = 1'b0;
`endif

  // Adder drives: only the active direction is driven, and only while settling
  always_comb begin
    f_a    = '0;
    f_b    = '0;
    f_c0_f = 1'b0;
    f_z    = 1'b0;
    r_s    = '0;
    r_a_b  = '0;
    r_c0_b = 1'b0;
    r_c15  = 1'b0;
    if (state == S_SETTLE) begin
      if (!op_q) begin
        f_a    = a_q;
        f_b    = b_q;
        f_c0_f = c0_q;
        f_z    = z_q;
      end else begin
        {r_s, r_a_b, r_c0_b, r_c15} = top_entry;
      end
    end
  end

  // Next-state logic; rejected requests skip straight to the response
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt = '0;
          if (req_err)          state_nxt = S_RESP;
          else if (in_op != dir) state_nxt = S_TURN;
          else                  state_nxt = S_SETTLE;
        end
      end
      S_TURN: begin
        if (last_turn) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (last_settle) begin
          state_nxt = S_RESP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any request in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture, direction ownership and stack occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      c0_q  <= 1'b0;
      z_q   <= 1'b0;
      dir   <= 1'b0;
      depth <= '0;
    end else begin
      if (accept) begin
        op_q <= in_op;
        a_q  <= in_a;
        b_q  <= in_b;
        c0_q <= in_c0;
        z_q  <= in_z;
        if (!req_err && (in_op != dir)) dir <= ~dir;
      end
      if (last_settle) depth <= op_q ? depth - 1'b1 : depth + 1'b1;
    end
  end

  // History stack write on the last compute settle cycle; contents are never reset
  always_ff @(posedge clk) begin
    if (last_settle && !op_q) begin
      mem[push_idx] <= {f_s, f_a_b, f_c0_b, f_c15};
`ifdef FA16_REV_SEQ_CHECK_EN
      chk_mem[push_idx] <= {a_q, b_q, c0_q, z_q};
`endif
    end
  end

  // Response registers; fields of the other operation type read 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_op       <= 1'b0;
      out_err      <= 1'b0;
      out_mismatch <= 1'b0;
      out_s        <= '0;
      out_c15      <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_c0       <= 1'b0;
      out_z        <= 1'b0;
    end else if (accept && req_err) begin
      out_op       <= in_op;
      out_err      <= 1'b1;
      out_mismatch <= 1'b0;
      out_s        <= '0;
      out_c15      <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_c0       <= 1'b0;
      out_z        <= 1'b0;
    end else if (last_settle) begin
      out_op  <= op_q;
      out_err <= 1'b0;
      if (!op_q) begin
        out_s        <= f_s;
        out_c15      <= f_c15;
        out_a        <= '0;
        out_b        <= '0;
        out_c0       <= 1'b0;
        out_z        <= 1'b0;
        out_mismatch <= 1'b0;
      end else begin
        out_s        <= '0;
        out_c15      <= 1'b0;
        out_a        <= r_a;
        out_b        <= r_b;
        out_c0       <= r_c0_f;
        out_z        <= r_z;
        out_mismatch <= recov_mismatch;
      end
    end
  end

endmodule
